// File: rtl/bali_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bali_io_pkg                                                  |
// | Description : Shared serializer state encoding and byte-lane select helper.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package bali_io_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam int C_MAX_BYTES = 8;

    // Words narrower than 64 bits are zero-extended by the caller.
    function automatic logic [7:0] byte_lane(input logic [63:0] word, input logic [2:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock FIFO, power-of-two depth, wrap-bit full/empty.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flags depend only on registered pointers, so the pop side never reaches full.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_serializer                                              |
// | Description : Buffers words and feeds them byte-by-byte to a UART TX.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module word_serializer
    import bali_io_pkg::*;
#(
    parameter int NBYTES     = 4,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*NBYTES-1:0]           in_word,
    input  logic [$clog2(NBYTES+1)-1:0]   in_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    tx_byte,
    output logic                          tx_send,
    input  logic                          tx_sent,
    output logic                          done,
    output logic                          busy
);

    localparam int         WW       = 8 * NBYTES;
    localparam logic [3:0] LEN_FULL = 4'(NBYTES);

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      rem_q, rem_d;
    logic [7:0]      tx_byte_q, tx_byte_d;

    logic [3:0]      in_len_ext;
    logic [3:0]      in_len_eff;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [WW+3:0]   fifo_data;
    logic [WW-1:0]   head_word;
    logic [3:0]      head_len;
    logic [63:0]     head_ext;
    logic [63:0]     word_ext;
    logic [2:0]      first_idx;
    logic [2:0]      next_idx;

    // Length is normalised before buffering so the FSM only sees 1..NBYTES.
    always_comb begin
        in_len_ext = 4'(in_len);
        in_len_eff = in_len_ext;
        if (in_len_ext == 4'd0 || in_len_ext > LEN_FULL) begin
            in_len_eff = LEN_FULL;
        end
    end

    sync_fifo #(
        .WIDTH (WW + 4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_data ({in_len_eff, in_word}),
        .push      (in_valid),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_word = fifo_data[WW-1:0];
    assign head_len  = fifo_data[WW+3:WW];

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        tx_byte_d = tx_byte_q;
        fifo_pop  = 1'b0;

        head_ext           = '0;
        head_ext[WW-1:0]   = head_word;
        word_ext           = '0;
        word_ext[WW-1:0]   = word_q;
        first_idx          = (MSB_FIRST != 0) ? 3'(head_len - 4'd1) : 3'd0;
        next_idx           = (MSB_FIRST != 0) ? (idx_q - 3'd1) : (idx_q + 3'd1);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    word_d    = head_word;
                    idx_d     = first_idx;
                    rem_d     = head_len - 4'd1;
                    tx_byte_d = byte_lane(head_ext, first_idx);
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_sent) begin
                    if (rem_q != 4'd0) begin
                        idx_d     = next_idx;
                        rem_d     = rem_q - 4'd1;
                        tx_byte_d = byte_lane(word_ext, next_idx);
                        state_d   = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign in_ready = !fifo_full;
    assign tx_byte  = tx_byte_q;
    assign tx_send  = (state_q == ST_SEND);
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter NBYTES, default 4: bytes per input word; legal range 1..8.
REQ-002 Parameter MSB_FIRST, default 0: 0 sends byte 0 (bits 7:0) first, 1 sends byte NBYTES-1 first.
REQ-003 Parameter FIFO_DEPTH, default 2: input word buffer depth; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_word  in  8*NBYTES  word to transmit.
REQ-007 in_len  in  clog2(NBYTES+1)  byte count to send; 0 or any value above NBYTES means NBYTES.
REQ-008 in_valid  in  1  in_word/in_len offered this cycle.
REQ-009 in_ready  out  1  buffer can accept; a word is pushed when in_valid and in_ready are both high.
REQ-010 tx_byte  out  8  byte presented to the UART transmitter.
REQ-011 tx_send  out  1  one-cycle start pulse to the UART transmitter.
REQ-012 tx_sent  in  1  one-cycle pulse from the UART transmitter: current byte finished.
REQ-013 done  out  1  one-cycle pulse: last byte of a word finished.
REQ-014 busy  out  1  high whenever the state is not IDLE or the buffer is non-empty.

Function
REQ-015 in_ready SHALL equal NOT full; there SHALL be no combinational path from the pop side to in_ready.
REQ-016 A push while full SHALL be impossible by construction; in_valid with in_ready low SHALL NOT change buffer contents.
REQ-017 States SHALL be IDLE, SEND, WAIT and DONE.
REQ-018 IDLE with a non-empty buffer SHALL pop one entry, load the word and its effective length, set the index to the first byte, and enter SEND on the next edge.
REQ-019 SEND SHALL assert tx_send for exactly one cycle and enter WAIT.
REQ-020 tx_byte SHALL hold the indexed byte from the SEND cycle until the cycle after the matching tx_sent, with no glitching.
REQ-021 WAIT with tx_sent and bytes remaining SHALL advance the index (+1 for LSB-first, -1 for MSB-first) and enter SEND.
REQ-022 WAIT with tx_sent on the last byte SHALL enter DONE.
REQ-023 tx_sent outside WAIT SHALL be ignored.
REQ-024 DONE SHALL assert done for one cycle and return to IDLE.
REQ-025 A buffered word SHALL leave IDLE no later than one cycle after DONE, so back-to-back words incur one IDLE cycle.
REQ-026 With in_len=k and LSB-first, bytes 0..k-1 SHALL be sent; with MSB-first, bytes k-1..0 SHALL be sent.
REQ-027 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and both SHALL take effect.
REQ-028 Buffer pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-029 Latency from push into an empty, idle block to tx_send SHALL be 2 cycles.

Reset
REQ-030 While rst is high: state=IDLE, buffer empty, index=0, tx_byte=8'h00, tx_send=0, done=0, busy=0, in_ready=1.
REQ-031 rst asserted mid-word SHALL abandon the word and all buffered words, and SHALL NOT generate done.
REQ-032 After rst deasserts, the first tx_send SHALL follow only a new push.

Structure
REQ-033 The state enum and a byte-lane select function SHALL live in shared package bali_io_pkg.
REQ-034 The input buffer SHALL be a sub-module, sync_fifo (parameters WIDTH, DEPTH), reusable by other io blocks.

Verification
REQ-035 Defaults, push 32'hDEADBEEF, in_len=0, tx_sent 10 cycles after each tx_send -> tx_byte sequence EF,BE,AD,DE; four tx_send pulses; one done pulse after the 4th tx_sent.
REQ-036 MSB_FIRST=1, push 32'h01020304 -> sequence 01,02,03,04.
REQ-037 in_len=2, word 32'hAABBCCDD -> DD,CC then done; tx_send never pulses a third time.
REQ-038 FIFO_DEPTH=2, three pushes on consecutive cycles while the block is busy -> in_ready low after the 2nd accepted word; all accepted words emitted in order with one IDLE cycle between done and the next pop.
REQ-039 rst pulse after the 2nd tx_sent of a word, with one word buffered -> no done, buffer empty, tx_send stays low until a new push.
REQ-040 Stray tx_sent in IDLE and in SEND -> no state change and no index advance.
